// File: rtl/ddr2_resp_pkg.sv
// rtl/ddr2_resp_pkg.sv - shared encodings for the DDR2 device-side responder
package ddr2_resp_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD = 3'b000,
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_RSVD = 3'b110,
    CMD_NOP  = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_B0,
    ST_RD_B1,
    ST_WR_WAIT,
    ST_WR_B0,
    ST_WR_B1
  } state_e;

  localparam int         NUM_BANKS = 8;
  localparam logic [2:0] CL_MIN    = 3'd3;
  localparam logic [2:0] CL_MAX    = 3'd6;
  localparam logic [2:0] BL4_CODE  = 3'b010;

  function automatic logic cl_legal(input logic [2:0] cl);
    return (cl >= CL_MIN) && (cl <= CL_MAX);
  endfunction

endpackage

// File: rtl/resp_mem.sv
// rtl/resp_mem.sv - single-port 64-bit word store, synchronous write, registered read
module resp_mem #(
  parameter int AW = 8
) (
  input  logic          clk_90,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [2**AW];
  logic [63:0] rdata_q;

  // No reset: contents and last read word survive rst by design.
  always_ff @(posedge clk_90) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddr2_resp_model.sv
// rtl/ddr2_resp_model.sv - DDR2 device-side responder (mode reg, bank rows, BL4 bursts)
// Define RESP_CHECK_TIMING_EN to add per-bank tRCD/tRP checking and the err_timing port.
module ddr2_resp_model
  import ddr2_resp_pkg::*;
#(
  parameter int MEM_AW     = 8,
  parameter int CL_DEFAULT = 5,
  parameter int T_RCD      = 3,
  parameter int T_RP       = 3
) (
  input  logic        clk_90,
  input  logic        rst,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [2:0]  ba,
  input  logic [12:0] addr,
  input  logic [15:0] dq_in0,
  input  logic [15:0] dq_in1,
  output logic [15:0] dq_out0,
  output logic [15:0] dq_out1,
  output logic        dq_oe,
  output logic        dqs_en,
  output logic [2:0]  cl_cur,
  output logic        err_closed,
  output logic        err_busy,
  output logic        err_mode
`ifdef RESP_CHECK_TIMING_EN
  ,
  output logic        err_timing
`endif
);

  localparam int         ROW_W  = MEM_AW - 5;
  localparam logic [2:0] CL_RST = 3'(CL_DEFAULT);

  cmd_e                cmd;
  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          cl_q, cl_d;
  logic [NUM_BANKS-1:0] valid_q, valid_d;
  logic [ROW_W-1:0]    open_row_q [NUM_BANKS];
  logic [ROW_W-1:0]    open_row_d [NUM_BANKS];
  logic                err_closed_q, err_closed_d;
  logic                err_busy_q, err_busy_d;
  logic                err_mode_q, err_mode_d;
  logic [MEM_AW-1:0]   waddr_q, waddr_d;
  logic [MEM_AW-1:0]   cmd_idx, mem_addr;
  logic [31:0]         beat0_q, beat0_d;
  logic                mem_we, mem_re;
  logic [63:0]         mem_rdata;
  logic                unused_addr;

`ifdef RESP_CHECK_TIMING_EN
  localparam int             TCW      = 4;
  localparam logic [TCW-1:0] TCNT_ONE = TCW'(1);
  localparam logic [TCW-1:0] RCD_LOAD = TCW'(T_RCD - 1);
  localparam logic [TCW-1:0] RP_LOAD  = TCW'(T_RP - 1);
  logic [TCW-1:0] rcd_q [NUM_BANKS];
  logic [TCW-1:0] rcd_d [NUM_BANKS];
  logic [TCW-1:0] rp_q  [NUM_BANKS];
  logic [TCW-1:0] rp_d  [NUM_BANKS];
  logic           err_timing_q, err_timing_d;
`else
  logic unused_timing;
  assign unused_timing = (T_RCD > 0) ^ (T_RP > 0);
`endif

  // Only some address bits matter depending on the command and MEM_AW.
  assign unused_addr = ^addr;

  always_comb begin
    if (!cke || cs_n) begin
      cmd = CMD_NOP;
    end else begin
      cmd = cmd_e'({ras_n, cas_n, we_n});
    end
  end

  assign cmd_idx = {ba, open_row_q[ba], addr[3:2]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cl_d         = cl_q;
    valid_d      = valid_q;
    open_row_d   = open_row_q;
    err_closed_d = err_closed_q;
    err_busy_d   = err_busy_q;
    err_mode_d   = err_mode_q;
    waddr_d      = waddr_q;
    beat0_d      = beat0_q;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = waddr_q;
`ifdef RESP_CHECK_TIMING_EN
    err_timing_d = err_timing_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rcd_d[b] = (rcd_q[b] != '0) ? rcd_q[b] - TCNT_ONE : '0;
      rp_d[b]  = (rp_q[b]  != '0) ? rp_q[b]  - TCNT_ONE : '0;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        case (cmd)
          CMD_LOAD: begin
            if (ba == 3'd0) begin
              if (cl_legal(addr[6:4])) begin
                cl_d = addr[6:4];
              end else begin
                err_mode_d = 1'b1;
              end
              if (addr[2:0] != BL4_CODE) begin
                err_mode_d = 1'b1;
              end
            end
          end
          CMD_REF: begin
            if (|valid_q) begin
              err_mode_d = 1'b1;
            end
`ifdef RESP_CHECK_TIMING_EN
            for (int b = 0; b < NUM_BANKS; b++) begin
              if (rp_q[b] != '0) begin
                err_timing_d = 1'b1;
              end
            end
`endif
          end
          CMD_PRE: begin
            if (addr[10]) begin
              valid_d = '0;
`ifdef RESP_CHECK_TIMING_EN
              for (int b = 0; b < NUM_BANKS; b++) begin
                rp_d[b] = RP_LOAD;
              end
`endif
            end else begin
              valid_d[ba] = 1'b0;
`ifdef RESP_CHECK_TIMING_EN
              rp_d[ba] = RP_LOAD;
`endif
            end
          end
          CMD_ACT: begin
            if (valid_q[ba]) begin
              err_closed_d = 1'b1;
            end
            valid_d[ba]    = 1'b1;
            open_row_d[ba] = addr[ROW_W-1:0];
`ifdef RESP_CHECK_TIMING_EN
            if (rp_q[ba] != '0) begin
              err_timing_d = 1'b1;
            end
            rcd_d[ba] = RCD_LOAD;
`endif
          end
          CMD_RD, CMD_WR: begin
            if (!valid_q[ba]) begin
              err_closed_d = 1'b1;
            end else begin
`ifdef RESP_CHECK_TIMING_EN
              if (rcd_q[ba] != '0) begin
                err_timing_d = 1'b1;
              end
`endif
              // Wait count places beat0 on the edge t+CL-1.
              cnt_d    = cl_q - 3'd2;
              waddr_d  = cmd_idx;
              mem_addr = cmd_idx;
              if (cmd == CMD_RD) begin
                mem_re  = 1'b1;
                state_d = ST_RD_WAIT;
              end else begin
                state_d = ST_WR_WAIT;
              end
            end
          end
          default: ;
        endcase
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = (state_q == ST_RD_WAIT) ? ST_RD_B0 : ST_WR_B0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RD_B0: state_d = ST_RD_B1;
      ST_RD_B1: state_d = ST_IDLE;
      ST_WR_B0: begin
        beat0_d = {dq_in0, dq_in1};
        state_d = ST_WR_B1;
      end
      ST_WR_B1: begin
        mem_we  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && cmd != CMD_NOP && cmd != CMD_RSVD) begin
      err_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_90) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cl_q         <= CL_RST;
      valid_q      <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        open_row_q[b] <= '0;
      end
      err_closed_q <= 1'b0;
      err_busy_q   <= 1'b0;
      err_mode_q   <= 1'b0;
      waddr_q      <= '0;
      beat0_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cl_q         <= cl_d;
      valid_q      <= valid_d;
      open_row_q   <= open_row_d;
      err_closed_q <= err_closed_d;
      err_busy_q   <= err_busy_d;
      err_mode_q   <= err_mode_d;
      waddr_q      <= waddr_d;
      beat0_q      <= beat0_d;
    end
  end

`ifdef RESP_CHECK_TIMING_EN
  always_ff @(posedge clk_90) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= '0;
        rp_q[b]  <= '0;
      end
      err_timing_q <= 1'b0;
    end else begin
      rcd_q        <= rcd_d;
      rp_q         <= rp_d;
      err_timing_q <= err_timing_d;
    end
  end

  assign err_timing = err_timing_q;
`endif

  resp_mem #(
    .AW(MEM_AW)
  ) u_mem (
    .clk_90 (clk_90),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i({beat0_q, dq_in0, dq_in1}),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    dq_oe   = 1'b0;
    dqs_en  = 1'b0;
    dq_out0 = '0;
    dq_out1 = '0;
    case (state_q)
      ST_RD_B0: begin
        dq_oe   = 1'b1;
        dqs_en  = 1'b1;
        dq_out0 = mem_rdata[63:48];
        dq_out1 = mem_rdata[47:32];
      end
      ST_RD_B1: begin
        dq_oe   = 1'b1;
        dqs_en  = 1'b1;
        dq_out0 = mem_rdata[31:16];
        dq_out1 = mem_rdata[15:0];
      end
      default: ;
    endcase
  end

  assign cl_cur     = cl_q;
  assign err_closed = err_closed_q;
  assign err_busy   = err_busy_q;
  assign err_mode   = err_mode_q;

endmodule

// File: doc/ddr2_resp_model.md
Name: ddr2_resp_model

Overview:
- Synthesizable DDR2 device-side responder; the target end of the DDR2 command/data interface driven by the team's DDR2 controller.
- Samples commands on clk_90, which is centred in the controller's command window. Tracks the mode register and per-bank open rows, stores write bursts and returns read bursts at the programmed CAS latency.
- Used in FPGA loopback and in simulation benches as a lightweight memory, with sticky protocol-error flags.

Parameters:
- MEM_AW, 8, word-address width of internal store (64-bit words, one per BL4 burst)
- CL_DEFAULT, 5, CAS latency before first MR load
- T_RCD, 3, min clk_90 cycles from ACT to RD/WR of the same bank (checked only with feature)
- T_RP, 3, min cycles from PRE to ACT/REF (checked only with feature)

Ports:
- clk_90  in  1  sampling clock
- rst  in  1  synchronous, active-high reset
- cke  in  1  clock enable; low forces every command to NOP
- cs_n  in  1  chip select; high forces NOP
- ras_n, cas_n, we_n  in  1 each  command bits
- ba  in  3  bank address
- addr  in  13  row/column/mode address
- dq_in0, dq_in1  in  16 each  rising/falling write halves from the input DDR register
- dq_out0, dq_out1  out  16 each  rising/falling read halves to the output DDR register
- dq_oe  out  1  read data drive enable
- dqs_en  out  1  read strobe enable
- cl_cur  out  3  current CAS latency
- err_closed  out  1  sticky: RD/WR to a closed bank, or ACT to an open bank
- err_busy  out  1  sticky: RD/WR/LOAD/ACT/PRE/REF issued during an active burst
- err_mode  out  1  sticky: illegal CL or BL in MR load, or REF with any bank open

Behaviour:
- Command code {ras_n,cas_n,we_n}: 000 LOAD, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 111 NOP; 110 is treated as NOP.
- Reset:
  - All outputs 0; cl_cur = CL_DEFAULT; BL = 4.
  - All banks closed; FSM to IDLE; memory contents untouched.
  - Reset mid-burst drops dq_oe/dqs_en on the next edge.
- LOAD, ba=0:
  - cl_cur <= addr[6:4] if in 3..6, else err_mode and old CL kept.
  - addr[2:0] must be 010, else err_mode.
  - LOAD to ba 1..3 is accepted and ignored.
- ACT: open_row[ba] <= addr; valid[ba] <= 1. ACT to an already-open bank sets err_closed and reopens the bank.
- PRE: addr[10]=1 closes all banks, else bank ba only.
- REF: sets err_mode if any bank is valid.
- Word index = {ba, open_row[ba][MEM_AW-6:0], addr[3:2]}, truncated to MEM_AW bits.
- Word ordering: [63:48] d0 beat0, [47:32] d1 beat0, [31:16] d0 beat1, [15:0] d1 beat1.
- FSM states: IDLE, RD_WAIT, RD_B0, RD_B1, WR_WAIT, WR_B0, WR_B1.
- Read:
  - RD accepted in IDLE at edge t; memory read issued at t.
  - RD_WAIT counts so that dq_oe = dqs_en = 1 in the cycles following edges t+CL-1 (beat0) and t+CL (beat1).
  - Returns to IDLE at t+CL+1.
- Write:
  - WR accepted at edge t; WL = CL-1.
  - dq_in sampled at edges t+WL+1 (beat0) and t+WL+2 (beat1).
  - Word written at t+WL+2; IDLE next.
- RD/WR to a closed bank sets err_closed; the command is dropped and the FSM stays IDLE.
- Any command other than NOP while the FSM is not IDLE sets err_busy and is ignored. The burst continues unaffected.
- Error flags are sticky until rst.
- When simultaneous with a busy burst, a command only sets err_busy; no bank-state change.

Optional Feature:
- Macro RESP_CHECK_TIMING_EN.
- Defined: per-bank counters enforce T_RCD (ACT to RD/WR) and T_RP (PRE to ACT/REF).
  - Violations assert extra port err_timing (out, 1, sticky).
  - The offending command still executes.
- Undefined: no counters and no err_timing port; timing is unchecked.

Decomposition:
- Package ddr2_resp_pkg: command encodings, FSM state enum, CL min/max constants (3/6), BL4 encoding 3'b010.
- One sub-module resp_mem: 2^MEM_AW x 64 single-port RAM with synchronous write and one-cycle registered read.

Test Plan:
- Reset, then LOAD ba=0 addr=0x052 (CL5, BL4) -> cl_cur=5, no error flags.
- ACT ba=2 row=0x0011; WR col 0x004 with beats {0xAAAA,0xBBBB},{0xCCCC,0xDDDD}; then RD same column -> dq_oe high for exactly 2 cycles starting at RD edge +4. Beat0 {0xAAAA,0xBBBB}, beat1 {0xCCCC,0xDDDD}.
- RD to bank 5 never activated -> err_closed=1, dq_oe stays 0.
- ACT issued 2 cycles after a RD (mid-burst) -> err_busy=1; read data still correct.
- LOAD addr[6:4]=7 -> err_mode=1, cl_cur remains 5. REF with bank 2 open -> err_mode=1.
- Assert rst during RD_B0 -> dq_oe/dqs_en=0 next edge, all banks closed, cl_cur=CL_DEFAULT. With RESP_CHECK_TIMING_EN, RD 1 cycle after ACT -> err_timing=1.
